riscv_lsu: RTL and testbench

Load/store unit that sits between the processor core's memory-access signals (driven by the main decoder's `mem_req_o` / `mem_we_o` / `mem_size_o` and the ALU address) and the external data memory. It converts byte, halfword and word accesses into byte-enabled 32-bit memory transactions. It stalls the core until the memory acknowledges, then sign- or zero-extends read data. It also detects misaligned accesses and memory timeouts, and reports both as single-cycle fault pulses.

---
 rtl/riscv_lsu.sv | 190 +++++++++++++++++++
 tb/tb_riscv_lsu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// ============================================================================
//  Module   : riscv_lsu
//  Purpose  : Load/store unit between the core and a 32-bit data memory.
//             Turns byte/halfword/word accesses into byte-enabled word
//             transactions, stalls the core until the memory acknowledges,
//             extends load data, and flags misaligned accesses and timeouts.
//  Ports    : clk_i, rst_i             clock, synchronous active-high reset
//             core_req_i/we_i/size_i   access request, store flag, size code
//             core_addr_i/core_wd_i    byte address, right-aligned store data
//             core_rd_o/core_stall_o   extended load data, core freeze
//             misaligned_o/timeout_o   one-cycle fault pulses
//             mem_req_o/we_o/be_o      memory request, write, byte enables
//             mem_addr_o/mem_wd_o      word address, replicated write data
//             mem_rd_i/mem_ready_i     memory read word, acknowledge
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  output logic        timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        cap_we;
  logic [2:0]  cap_size;
  logic [1:0]  cap_off;
  logic [29:0] cap_waddr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;

  logic        aligned;
  logic [3:0]  new_be;
  logic [31:0] new_wd;
  logic        last_wait;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Undefined size codes fall into the default branch and are rejected.
  always_comb begin
    case (core_size_i)
      3'd0, 3'd4: aligned = 1'b1;
      3'd1, 3'd5: aligned = ~core_addr_i[0];
      3'd2:       aligned = (core_addr_i[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end

  always_comb begin
    case (core_size_i[1:0])
      2'd0: begin
        new_be = 4'b0001 << core_addr_i[1:0];
        new_wd = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        new_be = 4'b0011 << core_addr_i[1:0];
        new_wd = {2{core_wd_i[15:0]}};
      end
      default: begin
        new_be = 4'b1111;
        new_wd = core_wd_i;
      end
    endcase
  end

  assign last_wait = (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    rd_byte = mem_rd_i[8*cap_off +: 8];
    rd_half = mem_rd_i[16*cap_off[1] +: 16];
    case (cap_size)
      3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
      3'd2:    rd_ext = mem_rd_i;
      3'd4:    rd_ext = {24'd0, rd_byte};
      3'd5:    rd_ext = {16'd0, rd_half};
      default: rd_ext = 32'd0;
    endcase
  end

  // Outputs are combinational so an aligned request reaches memory in its
  // issue cycle and load data is available in the ready cycle.
  always_comb begin
    core_rd_o    = 32'd0;
    core_stall_o = 1'b0;
    misaligned_o = 1'b0;
    timeout_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (core_req_i) begin
            if (aligned) begin
              mem_req_o    = 1'b1;
              mem_we_o     = core_we_i;
              mem_be_o     = new_be;
              mem_addr_o   = {core_addr_i[31:2], 2'b00};
              mem_wd_o     = new_wd;
              core_stall_o = 1'b1;
            end else begin
              misaligned_o = 1'b1;
            end
          end
        end
        WAIT: begin
          // Ready beats a coincident timeout.
          if (mem_ready_i || !last_wait) begin
            mem_req_o    = 1'b1;
            mem_we_o     = cap_we;
            mem_be_o     = cap_be;
            mem_addr_o   = {cap_waddr, 2'b00};
            mem_wd_o     = cap_wd;
            core_stall_o = ~mem_ready_i;
            if (mem_ready_i && !cap_we) begin
              core_rd_o = rd_ext;
            end
          end else begin
            timeout_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      cap_we    <= 1'b0;
      cap_size  <= 3'd0;
      cap_off   <= 2'd0;
      cap_waddr <= 30'd0;
      cap_be    <= 4'd0;
      cap_wd    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i && aligned) begin
            cap_we    <= core_we_i;
            cap_size  <= core_size_i;
            cap_off   <= core_addr_i[1:0];
            cap_waddr <= core_addr_i[31:2];
            cap_be    <= new_be;
            cap_wd    <= new_wd;
            cnt       <= 8'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready_i || last_wait) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
// ============================================================================
//  Module   : tb_riscv_lsu
//  Purpose  : Self-checking bench for riscv_lsu. A transaction-level model
//             predicts every output each cycle; directed sequences pin the
//             model with literal values, then random traffic follows.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'd0;
  logic [31:0] core_wd_i = 32'd0;
  logic [31:0] mem_rd_i = 32'd0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] core_rd_o;
  logic        core_stall_o, misaligned_o, timeout_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;

  int checks = 0;
  int failures = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o),
    .misaligned_o(misaligned_o), .timeout_o(timeout_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model helpers ----------------
  function automatic int nbytes(input logic [2:0] s);
    return 1 << (int'(s) % 4);
  endfunction

  function automatic bit m_aligned(input logic [2:0] s, input logic [31:0] a);
    if (s == 3'd3 || s > 3'd5) return 1'b0;
    return (int'(a % 4) % nbytes(s)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int mask;
    mask = (1 << nbytes(s)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
    if (nbytes(s) == 1) return {24'd0, d[7:0]} * 32'h01010101;
    if (nbytes(s) == 2) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    logic [7:0]  b;
    logic [15:0] h;
    v = w >> (8 * (a % 4));
    b = v[7:0];
    h = v[15:0];
    case (s)
      3'd0: return 32'($signed(b));
      3'd1: return 32'($signed(h));
      3'd4: return {24'd0, b};
      3'd5: return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- model + compare process ----------------
  bit          busy = 1'b0;
  int          k = 0;
  logic        t_we;
  logic [2:0]  t_size;
  logic [31:0] t_addr, t_wd;

  initial begin
    logic [31:0] e_rd, e_addr, e_wd;
    logic        e_stall, e_mis, e_to, e_req, e_we;
    logic [3:0]  e_be;
    forever begin
      @(negedge clk);
      e_rd = 0; e_addr = 0; e_wd = 0; e_be = 0;
      e_stall = 0; e_mis = 0; e_to = 0; e_req = 0; e_we = 0;
      if (rst_i) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (core_req_i) begin
          if (m_aligned(core_size_i, core_addr_i)) begin
            t_we = core_we_i; t_size = core_size_i;
            t_addr = core_addr_i; t_wd = core_wd_i;
            e_req = 1; e_stall = 1;
            e_we = t_we; e_be = m_be(t_size, t_addr);
            e_addr = t_addr & ~32'd3; e_wd = m_wd(t_size, t_wd);
            busy = 1'b1; k = 0;
          end else begin
            e_mis = 1;
          end
        end
      end else begin
        k++;  // k-th cycle spent waiting on memory
        if (mem_ready_i || k < T) begin
          e_req = 1;
          e_we = t_we; e_be = m_be(t_size, t_addr);
          e_addr = t_addr & ~32'd3; e_wd = m_wd(t_size, t_wd);
          e_stall = !mem_ready_i;
          if (mem_ready_i) begin
            if (!t_we) e_rd = m_load(t_size, t_addr, mem_rd_i);
            busy = 1'b0;
          end
        end else begin
          e_to = 1;
          busy = 1'b0;
        end
      end
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, e_req});
      chk("core_stall", {31'd0, core_stall_o}, {31'd0, e_stall});
      chk("misaligned", {31'd0, misaligned_o}, {31'd0, e_mis});
      chk("timeout", {31'd0, timeout_o}, {31'd0, e_to});
      chk("core_rd", core_rd_o, e_rd);
      if (e_req) begin
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, e_we});
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, e_be});
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wd", mem_wd_o, e_wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic r, input logic q, input logic w, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic [31:0] mrd);
    @(posedge clk);
    #1;
    rst_i = r; core_req_i = q; core_we_i = w; core_size_i = s;
    core_addr_i = a; core_wd_i = d; mem_ready_i = rdy; mem_rd_i = mrd;
    #2;
  endtask

  initial begin
    // Reset with a request present: outputs must stay 0.
    drv(1, 1, 1, 3'd2, 32'h100, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
    chk("lit_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("lit_rst_stall", {31'd0, core_stall_o}, 32'd0);

    // SW 0x100, ready in 2nd WAIT cycle.
    drv(0, 1, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0);
    chk("lit_sw_be", {28'd0, mem_be_o}, 32'hF);
    chk("lit_sw_addr", mem_addr_o, 32'h100);
    chk("lit_sw_wd", mem_wd_o, 32'hDEADBEEF);
    chk("lit_sw_we", {31'd0, mem_we_o}, 32'd1);
    chk("lit_sw_stall0", {31'd0, core_stall_o}, 32'd1);
    drv(0, 1, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0);
    chk("lit_sw_stall1", {31'd0, core_stall_o}, 32'd1);
    drv(0, 1, 1, 3'd2, 32'h100, 32'hDEADBEEF, 1, 0);
    chk("lit_sw_stall2", {31'd0, core_stall_o}, 32'd0);
    drv(0, 0, 0, 3'd0, 0, 0, 0, 0);

    // LB / LBU at 0x103.
    drv(0, 1, 0, 3'd0, 32'h103, 0, 0, 0);
    chk("lit_lb_be", {28'd0, mem_be_o}, 32'h8);
    drv(0, 1, 0, 3'd0, 32'h103, 0, 1, 32'h80000000);
    chk("lit_lb_rd", core_rd_o, 32'hFFFFFF80);
    drv(0, 1, 0, 3'd4, 32'h103, 0, 0, 0);
    drv(0, 1, 0, 3'd4, 32'h103, 0, 1, 32'h80000000);
    chk("lit_lbu_rd", core_rd_o, 32'h00000080);

    // SH at 0x102, address changes during WAIT.
    drv(0, 1, 1, 3'd1, 32'h102, 32'h1234ABCD, 0, 0);
    chk("lit_sh_wd", mem_wd_o, 32'hABCDABCD);
    chk("lit_sh_be", {28'd0, mem_be_o}, 32'hC);
    chk("lit_sh_addr", mem_addr_o, 32'h100);
    drv(0, 1, 1, 3'd1, 32'h200, 32'h0, 0, 0);
    chk("lit_sh_hold_addr", mem_addr_o, 32'h100);
    chk("lit_sh_hold_wd", mem_wd_o, 32'hABCDABCD);
    drv(0, 1, 1, 3'd1, 32'h200, 32'h0, 1, 0);

    // Misaligned LW then aligned LW.
    drv(0, 1, 0, 3'd2, 32'h101, 0, 0, 0);
    chk("lit_mis_pulse", {31'd0, misaligned_o}, 32'd1);
    chk("lit_mis_req", {31'd0, mem_req_o}, 32'd0);
    chk("lit_mis_stall", {31'd0, core_stall_o}, 32'd0);
    drv(0, 1, 0, 3'd2, 32'h104, 0, 0, 0);
    chk("lit_mis_next_req", {31'd0, mem_req_o}, 32'd1);
    chk("lit_mis_next_pulse", {31'd0, misaligned_o}, 32'd0);
    drv(0, 1, 0, 3'd2, 32'h104, 0, 1, 32'h0BADF00D);
    chk("lit_lw_rd", core_rd_o, 32'h0BADF00D);

    // Timeout: ready held low.
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    chk("lit_to_stall3", {31'd0, core_stall_o}, 32'd1);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    chk("lit_to_pulse", {31'd0, timeout_o}, 32'd1);
    chk("lit_to_stall", {31'd0, core_stall_o}, 32'd0);
    chk("lit_to_req", {31'd0, mem_req_o}, 32'd0);
    drv(0, 0, 0, 3'd0, 0, 0, 0, 0);
    chk("lit_to_once", {31'd0, timeout_o}, 32'd0);
    // Ready in the 4th WAIT cycle wins.
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h10, 0, 1, 32'h55AA55AA);
    chk("lit_late_rd", core_rd_o, 32'h55AA55AA);
    chk("lit_late_nopulse", {31'd0, timeout_o}, 32'd0);
    drv(0, 0, 0, 3'd0, 0, 0, 0, 0);

    // Reset during WAIT, then back-to-back LW / SW.
    drv(0, 1, 0, 3'd2, 32'h200, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h200, 0, 0, 0);
    drv(1, 1, 0, 3'd2, 32'h200, 0, 1, 32'hFFFFFFFF);
    chk("lit_wrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("lit_wrst_rd", core_rd_o, 32'd0);
    drv(0, 0, 0, 3'd2, 32'h200, 0, 1, 0);
    chk("lit_after_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("lit_after_rst_to", {31'd0, timeout_o}, 32'd0);
    drv(0, 1, 0, 3'd2, 32'h204, 0, 0, 0);
    drv(0, 1, 0, 3'd2, 32'h204, 0, 1, 32'h11223344);
    chk("lit_b2b_rd", core_rd_o, 32'h11223344);
    drv(0, 1, 1, 3'd2, 32'h208, 32'h55, 0, 0);
    chk("lit_b2b_req", {31'd0, mem_req_o}, 32'd1);
    chk("lit_b2b_we", {31'd0, mem_we_o}, 32'd1);
    drv(0, 1, 1, 3'd2, 32'h208, 32'h55, 1, 0);
    drv(0, 0, 0, 3'd0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       w;
      logic [2:0] s;
      int         p;
      w = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 19);
      if (w) s = (p < 6) ? 3'd0 : (p < 12) ? 3'd1 : (p < 18) ? 3'd2 : 3'd3;
      else   s = (p < 4) ? 3'd0 : (p < 8) ? 3'd1 : (p < 12) ? 3'd2 :
                 (p < 15) ? 3'd4 : (p < 18) ? 3'd5 : 3'($urandom_range(6, 7));
      drv(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), w, s,
          $urandom, $urandom, ($urandom_range(0, 9) < 4), $urandom);
    end
    drv(0, 0, 0, 3'd0, 0, 0, 1, 0);
    @(posedge clk);
    #7;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
